fetch_unit: RTL and testbench

//  Instruction fetch stage, directly upstream of the field decoder. Keeps the PC and

---
 rtl/core_pkg.sv | 25 ++
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core types and constants for the instruction fetch stage.
package core_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t INSN_NOP         = 32'h0000_0013;
  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;
  localparam word_t PC_STEP          = 32'd4;

  // One buffered instruction: its PC plus the fetched word.
  typedef struct packed {
    word_t pc;
    word_t insn;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // Force a PC onto a word boundary.
  function automatic word_t align_pc(input word_t pc);
    return pc & ~word_t'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory req/gnt/rvalid, redirect and decoder handshake.
interface fetch_unit_if;
  import core_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_gnt;
  logic  imem_rvalid;
  word_t imem_rdata;
  logic  redirect;
  word_t redirect_pc;
  logic  ins_valid;
  logic  ins_ready;
  word_t ins;
  word_t ins_pc;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr, ins_valid, ins, ins_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, ins_ready
  );

  // Memory / pipeline side.
  modport slave (
    input  imem_req, imem_addr, ins_valid, ins, ins_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, ins_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer; flush wins over push, head is shown combinationally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && !empty_o;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed while the entry is counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, request credits, stale-response dropping and output buffer.
module fetch_unit
  import core_pkg::*;
#(
  parameter word_t       RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master fu
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);

  word_t            pc_q, pc_d;
  word_t            resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  fetch_entry_t     fifo_head;
  fetch_entry_t     fifo_wdata;
  logic             credit_ok;
  logic             req_c;
  logic             fire;
  logic             push;
  logic             pop;

  // A slot is reserved in the buffer for every read in flight, so pushes never overflow.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CNT_W+1)'(FIFO_DEPTH);
  assign req_c     = !rst && !fu.redirect && credit_ok;
  assign fire      = req_c && fu.imem_gnt;
  assign push      = fu.imem_rvalid && !fu.redirect && (drop_q == '0);
  assign pop       = !fifo_empty && fu.ins_ready;

  assign fifo_wdata = '{pc: resp_pc_q, insn: fu.imem_rdata};

  assign fu.imem_req  = req_c;
  assign fu.imem_addr = pc_q;
  assign fu.ins_valid = !fifo_empty;
  assign fu.ins       = fifo_empty ? INSN_NOP : fifo_head.insn;
  assign fu.ins_pc    = fifo_empty ? RESET_PC : fifo_head.pc;

  // Next-state for PC, response PC, credit and drop counters; redirect overrides all.
  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (fu.redirect) begin
      pc_d          = align_pc(fu.redirect_pc);
      resp_pc_d     = align_pc(fu.redirect_pc);
      outstanding_d = outstanding_q - CNT_W'(fu.imem_rvalid);
      drop_d        = outstanding_q - CNT_W'(fu.imem_rvalid);
    end else begin
      if (fire) pc_d = pc_q + PC_STEP;
      outstanding_d = outstanding_q + CNT_W'(fire) - CNT_W'(fu.imem_rvalid);
      if (fu.imem_rvalid) begin
        if (drop_q != '0) drop_d = drop_q - CNT_W'(1);
        else              resp_pc_d = resp_pc_q + PC_STEP;
      end
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (fifo_wdata),
    .pop_i   (pop),
    .flush_i (fu.redirect),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle-latency instruction memory model.
module tb_fetch_unit;
  import core_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  gnt_en, rv_en, ready, redir;
  word_t redir_pc;
  logic  mem_rvalid;
  word_t mem_rdata;
  word_t mq[$];

  int    n_chk  = 0;
  int    n_pass = 0;
  word_t acc_pc [8];
  int    acc_n;

  always #5 clk = ~clk;

  fetch_unit_if bus();

  assign bus.imem_gnt    = gnt_en;
  assign bus.imem_rvalid = mem_rvalid;
  assign bus.imem_rdata  = mem_rdata;
  assign bus.redirect    = redir;
  assign bus.redirect_pc = redir_pc;
  assign bus.ins_ready   = ready;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .fu  (bus)
  );

  function automatic word_t mem_f(input word_t a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Memory: accepted address answered in the following cycle when rv_en is set.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      if (bus.imem_req && bus.imem_gnt) mq.push_back(bus.imem_addr);
      if (rv_en && mq.size() > 0) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= mem_f(mq.pop_front());
      end else begin
        mem_rvalid <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; gnt_en = 1'b0; rv_en = 1'b1; ready = 1'b0; redir = 1'b0; redir_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Gather up to n accepted instructions, checking each word against its PC.
  task automatic collect(input int n, input int budget);
    acc_n = 0;
    for (int c = 0; c < budget && acc_n < n; c++) begin
      #1;
      if (bus.ins_valid && ready) begin
        acc_pc[acc_n] = bus.ins_pc;
        chk("accepted ins data", bus.ins, mem_f(bus.ins_pc));
        acc_n++;
      end
      @(negedge clk);
    end
    chk("accepted ins count", 32'(acc_n), 32'(n));
  endtask

  typedef struct {
    logic  gnt;
    logic  rdy;
    logic  req;
    word_t addr;
    logic  valid;
    word_t pc;
  } vec_t;

  vec_t t1 [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int grants;
    int moved;

    // Reset values.
    rst = 1'b1; gnt_en = 1'b0; rv_en = 1'b1; ready = 1'b0; redir = 1'b0; redir_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset imem_req",  32'(bus.imem_req),  32'd0);
    chk("reset imem_addr", bus.imem_addr,      32'h0);
    chk("reset ins_valid", 32'(bus.ins_valid), 32'd0);
    chk("reset ins",       bus.ins,            32'h0000_0013);
    chk("reset ins_pc",    bus.ins_pc,         32'h0);
    rst = 1'b0;

    // Streaming with gnt=1, ready=1: depth-2 credits give two fetches per three cycles.
    t1[0] = '{gnt: 1, rdy: 1, req: 1, addr: 32'h00, valid: 0, pc: 32'h0};
    t1[1] = '{gnt: 1, rdy: 1, req: 1, addr: 32'h04, valid: 0, pc: 32'h0};
    t1[2] = '{gnt: 1, rdy: 1, req: 0, addr: 32'h08, valid: 1, pc: 32'h0};
    t1[3] = '{gnt: 1, rdy: 1, req: 1, addr: 32'h08, valid: 1, pc: 32'h4};
    t1[4] = '{gnt: 1, rdy: 1, req: 1, addr: 32'h0C, valid: 0, pc: 32'h0};
    t1[5] = '{gnt: 1, rdy: 1, req: 0, addr: 32'h10, valid: 1, pc: 32'h8};
    t1[6] = '{gnt: 1, rdy: 1, req: 1, addr: 32'h10, valid: 1, pc: 32'hC};
    t1[7] = '{gnt: 1, rdy: 1, req: 1, addr: 32'h14, valid: 0, pc: 32'h0};
    for (int i = 0; i < 8; i++) begin
      gnt_en = t1[i].gnt;
      ready  = t1[i].rdy;
      #1;
      chk($sformatf("t1[%0d] imem_req", i),  32'(bus.imem_req),  32'(t1[i].req));
      chk($sformatf("t1[%0d] imem_addr", i), bus.imem_addr,      t1[i].addr);
      chk($sformatf("t1[%0d] ins_valid", i), 32'(bus.ins_valid), 32'(t1[i].valid));
      if (t1[i].valid) begin
        chk($sformatf("t1[%0d] ins_pc", i), bus.ins_pc, t1[i].pc);
        chk($sformatf("t1[%0d] ins", i),    bus.ins,    mem_f(t1[i].pc));
      end
      @(negedge clk);
    end

    // Downstream stalled for 10 cycles: two requests, buffer full, head held.
    do_reset();
    gnt_en = 1'b1; ready = 1'b0;
    grants = 0; moved = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.imem_req && bus.imem_gnt) grants++;
      if (bus.ins_valid && bus.ins_pc != 32'h0) moved++;
      @(negedge clk);
    end
    #1;
    chk("stall grant count", 32'(grants), 32'd2);
    chk("stall head moved",  32'(moved),  32'd0);
    chk("stall ins_valid",   32'(bus.ins_valid), 32'd1);
    chk("stall ins_pc",      bus.ins_pc, 32'h0);
    chk("stall imem_req",    32'(bus.imem_req), 32'd0);
    @(negedge clk);
    ready = 1'b1;
    collect(3, 30);
    chk("stall order 0", acc_pc[0], 32'h0);
    chk("stall order 1", acc_pc[1], 32'h4);
    chk("stall order 2", acc_pc[2], 32'h8);

    // Redirect with two reads in flight: both replies dropped.
    do_reset();
    gnt_en = 1'b1; ready = 1'b1; rv_en = 1'b0;
    repeat (2) @(negedge clk);
    redir = 1'b1; redir_pc = 32'h100; rv_en = 1'b1;
    #1;
    chk("redir2 imem_req in R", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    redir = 1'b0;
    #1;
    chk("redir2 imem_addr",  bus.imem_addr,      32'h100);
    chk("redir2 ins_valid",  32'(bus.ins_valid), 32'd0);
    @(negedge clk);
    collect(1, 20);
    chk("redir2 first ins_pc", acc_pc[0], 32'h100);

    // Misaligned redirect coinciding with rvalid: that word discarded.
    do_reset();
    gnt_en = 1'b1; ready = 1'b0; rv_en = 1'b1;
    @(negedge clk);
    redir = 1'b1; redir_pc = 32'h203;
    #1;
    chk("redir_rv rvalid in R",   32'(mem_rvalid),   32'd1);
    chk("redir_rv imem_req in R", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    redir = 1'b0;
    #1;
    chk("redir_rv imem_addr",  bus.imem_addr,      32'h200);
    chk("redir_rv imem_req",   32'(bus.imem_req),  32'd1);
    chk("redir_rv valid R+1",  32'(bus.ins_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("redir_rv valid R+2",  32'(bus.ins_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("redir_rv valid R+3",  32'(bus.ins_valid), 32'd1);
    chk("redir_rv ins_pc",     bus.ins_pc,         32'h200);
    chk("redir_rv ins",        bus.ins,            mem_f(32'h200));

    // Grant withheld: address held; then PC wrap at the top of memory.
    do_reset();
    gnt_en = 1'b0; ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("nogrant[%0d] req/addr", c), {31'(bus.imem_addr), bus.imem_req}, 32'h1);
      @(negedge clk);
    end
    redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redir = 1'b0; gnt_en = 1'b1;
    #1;
    chk("wrap addr top", bus.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    #1;
    chk("wrap addr zero", bus.imem_addr, 32'h0);
    @(negedge clk);
    collect(2, 20);
    chk("wrap ins_pc 0", acc_pc[0], 32'hFFFF_FFFC);
    chk("wrap ins_pc 1", acc_pc[1], 32'h0);

    // Asynchronous reset with two reads in flight.
    do_reset();
    gnt_en = 1'b1; ready = 1'b1; rv_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("arst pre addr", bus.imem_addr, 32'h8);
    rst = 1'b1;
    #1;
    chk("arst imem_req",  32'(bus.imem_req),  32'd0);
    chk("arst imem_addr", bus.imem_addr,      32'h0);
    chk("arst ins_valid", 32'(bus.ins_valid), 32'd0);
    chk("arst ins",       bus.ins,            32'h0000_0013);
    chk("arst ins_pc",    bus.ins_pc,         32'h0);
    @(negedge clk);
    rst = 1'b0; rv_en = 1'b1;
    #1;
    chk("arst restart addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    collect(1, 20);
    chk("arst first ins_pc", acc_pc[0], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
